pin_entry_collector: RTL and testbench
======================================

# pin_entry_collector

Keypad front end for the parking-gate controller. It receives one key strobe at a time from the debounced keypad and assembles two decimal digits into the 8-bit password bus the gate controller compares. It also handles clear, enter and inactivity timeout. The submitted password is held stable on `password` until the next successful submission, and each successful submission is flagged with a one-cycle `password_valid` pulse.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16'd1000: inactivity limit in COLLECT, in clock cycles. Legal range 2..65535.

Ports:
- `clk`  input  1  single clock; all state updates on posedge.
- `reset`  input  1  asynchronous, active-low reset. Assertion forces all registers immediately. Deassertion is sampled on posedge `clk`.
- `key_valid`  input  1  one-cycle strobe; each cycle it is high counts as one key press.
- `key_code`  input  4  key value, sampled only when `key_valid`=1:
  - 4'h0–4'h9: digits.
  - 4'hA: CLEAR.
  - 4'hB: ENTER.
  - 4'hC–4'hF: illegal.
- `password`  output  8  last submitted password, {first_digit, second_digit}. Held until the next accepted ENTER.
- `password_valid`  output  1  one-cycle pulse when `password` has just been updated.
- `entry_error`  output  1  one-cycle pulse on a rejected ENTER or an illegal code.
- `entry_timeout`  output  1  one-cycle pulse when a partial entry is discarded for inactivity.
- `entry_busy`  output  1  high while in COLLECT.
- `digit_count`  output  2  digits captured in the current entry (0..2).

## Operation
- Two states:
  - IDLE: no digits held.
  - COLLECT: 1 or 2 digits held.
- Internal registers:
  - `shift_reg` [7:0]
  - `overflow` flag
  - 16-bit `idle_cnt`
- IDLE:
  - digit key: shift_reg <= {4'h0, key}, digit_count <= 1, idle_cnt <= 0, go to COLLECT.
  - CLEAR: no effect.
  - ENTER or illegal code: pulse `entry_error`, remain in IDLE.
- COLLECT:
  - digit key with digit_count=1: shift_reg <= {shift_reg[3:0], key}, digit_count <= 2.
  - digit key with digit_count=2: shift_reg unchanged, `overflow` <= 1, digit_count stays 2.
  - ENTER with digit_count=2 and overflow=0: password <= shift_reg, pulse `password_valid`, go to IDLE.
  - ENTER otherwise (1 digit, or overflow): pulse `entry_error`, `password` unchanged, go to IDLE.
  - CLEAR: discard the entry and go to IDLE. No pulse.
  - illegal code: pulse `entry_error`, discard the entry, go to IDLE.
  - every `key_valid` cycle resets idle_cnt to 0; otherwise idle_cnt increments.
  - idle_cnt == TIMEOUT_CYCLES-1 with no key that cycle: pulse `entry_timeout`, go to IDLE.
- Any return to IDLE clears shift_reg, overflow, idle_cnt and digit_count.
- `password` is never modified except by an accepted ENTER. Downstream may compare it continuously.
- Unreachable state encodings recover to IDLE on the next clock.

## Timing
- Reset values:
  - state IDLE
  - password 8'h00
  - password_valid, entry_error, entry_timeout, entry_busy all 0
  - digit_count 0
  - shift_reg 0, overflow 0, idle_cnt 0
- All outputs are registered; no combinational path from inputs to outputs.
- Latency: ENTER sampled at edge N → `password` updated and `password_valid`=1 in cycle N+1 (after edge N). `password_valid` is 0 again after edge N+1.
- `entry_error` and `entry_timeout` follow the same one-cycle timing. At most one of `password_valid`, `entry_error`, `entry_timeout` is high in any cycle.
- Back-to-back strobes (key_valid high on consecutive cycles) are each processed. The first digit of a new entry is accepted in the cycle immediately after an ENTER.
- Timeout: the last key is at edge K. With no further keys, `entry_timeout` is high in the cycle after edge K+TIMEOUT_CYCLES-1.
- A key arriving on the same edge as the timeout match takes priority: the key is processed and there is no timeout.
- Reset asserted mid-entry:
  - outputs are forced to their reset values immediately;
  - the partial entry is lost;
  - the previously held `password` returns to 8'h00.

## Test plan
- Reset, then keys 4, 9, ENTER on consecutive cycles → password=8'h49 with password_valid=1 for exactly one cycle, digit_count=0, entry_busy=0.
- Keys 4, ENTER → entry_error pulse; password stays 8'h49 from the prior entry; no password_valid.
- Keys 1, 2, 3, ENTER → overflow; entry_error pulse; password unchanged. Then 1, 2, ENTER → password=8'h12.
- TIMEOUT_CYCLES=8: key 4, then 8 idle cycles → entry_timeout on cycle 7 after the key; entry_busy=0. A following 9, ENTER → entry_error (only one digit held).
- Key 7, CLEAR, then 0, 5, ENTER → password=8'h05. Separately, key 4'hE in IDLE → entry_error pulse.
- reset driven low asynchronously between clock edges while digit_count=1 → all outputs 0 immediately, without waiting for a clock edge. After release, 4, 9, ENTER → password=8'h49.

Source files
------------

// File: rtl/pin_entry_collector.sv
// ---------------------------------------------------------------------------
// pin_entry_collector
//
// Keypad front end for the parking-gate controller. Collects two decimal
// digits from the debounced keypad into an 8-bit password, and handles
// CLEAR, ENTER, illegal key codes and an inactivity timeout while an entry
// is in progress.
//
// Parameters:
//   TIMEOUT_CYCLES  inactivity limit while collecting (legal 2..65535)
//
// Ports:
//   clk             clock, all state updates on posedge
//   reset           asynchronous active-low reset
//   key_valid       one-cycle key strobe
//   key_code        4'h0-4'h9 digit, 4'hA CLEAR, 4'hB ENTER, others illegal
//   password        last accepted password {first_digit, second_digit}
//   password_valid  one-cycle pulse when password was just updated
//   entry_error     one-cycle pulse on rejected ENTER or illegal code
//   entry_timeout   one-cycle pulse when a partial entry timed out
//   entry_busy      high while an entry is being collected
//   digit_count     digits held in the current entry (0..2)
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module pin_entry_collector #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [7:0] password,
  output logic       password_valid,
  output logic       entry_error,
  output logic       entry_timeout,
  output logic       entry_busy,
  output logic [1:0] digit_count
);

  // One-hot style encoding so that the two unused encodings are detectable
  // and can be steered back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b01,
    ST_COLLECT = 2'b10
  } state_t;

  // Key classes returned by key_class().
  localparam logic [1:0] KC_DIGIT   = 2'd0;
  localparam logic [1:0] KC_CLEAR   = 2'd1;
  localparam logic [1:0] KC_ENTER   = 2'd2;
  localparam logic [1:0] KC_ILLEGAL = 2'd3;

  // Classify a raw key code.
  function automatic logic [1:0] key_class(input logic [3:0] code);
    logic [1:0] cls;
    case (code)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
      4'h5, 4'h6, 4'h7, 4'h8, 4'h9: cls = KC_DIGIT;
      4'hA:                         cls = KC_CLEAR;
      4'hB:                         cls = KC_ENTER;
      default:                      cls = KC_ILLEGAL;
    endcase
    return cls;
  endfunction

  state_t      state_r;
  logic [7:0]  shift_r;
  logic        overflow_r;
  logic [15:0] idle_cnt_r;

  logic [1:0]  key_class_s;
  logic [15:0] idle_next_s;
  logic        timeout_hit_s;

  // Key decode and inactivity counter look-ahead.
  always_comb begin
    key_class_s   = key_class(key_code);
    idle_next_s   = idle_cnt_r + 16'd1;
    // The counter is cleared on the key edge, so its incremented value is
    // the number of idle edges seen so far; the entry is dropped on the edge
    // where that count reaches TIMEOUT_CYCLES-1.
    timeout_hit_s = (idle_next_s == (TIMEOUT_CYCLES - 16'd1));
  end

  // Entry FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      shift_r        <= 8'h00;
      overflow_r     <= 1'b0;
      idle_cnt_r     <= 16'd0;
      password       <= 8'h00;
      password_valid <= 1'b0;
      entry_error    <= 1'b0;
      entry_timeout  <= 1'b0;
      entry_busy     <= 1'b0;
      digit_count    <= 2'd0;
    end else begin
      // Pulses default low; the branches below raise at most one of them.
      password_valid <= 1'b0;
      entry_error    <= 1'b0;
      entry_timeout  <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (key_valid) begin
            case (key_class_s)
              KC_DIGIT: begin
                shift_r     <= {4'h0, key_code};
                overflow_r  <= 1'b0;
                idle_cnt_r  <= 16'd0;
                digit_count <= 2'd1;
                entry_busy  <= 1'b1;
                state_r     <= ST_COLLECT;
              end
              KC_CLEAR: begin
                // Nothing to clear.
                state_r <= ST_IDLE;
              end
              default: begin
                // ENTER with no digits, or an illegal code.
                entry_error <= 1'b1;
                state_r     <= ST_IDLE;
              end
            endcase
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_COLLECT: begin
          if (key_valid) begin
            case (key_class_s)
              KC_DIGIT: begin
                idle_cnt_r <= 16'd0;
                if (digit_count == 2'd1) begin
                  shift_r     <= {shift_r[3:0], key_code};
                  digit_count <= 2'd2;
                end else begin
                  // A third digit poisons the entry; the held digits stay.
                  overflow_r  <= 1'b1;
                  digit_count <= 2'd2;
                end
              end
              KC_ENTER: begin
                if ((digit_count == 2'd2) && !overflow_r) begin
                  password       <= shift_r;
                  password_valid <= 1'b1;
                end else begin
                  entry_error <= 1'b1;
                end
                state_r     <= ST_IDLE;
                shift_r     <= 8'h00;
                overflow_r  <= 1'b0;
                idle_cnt_r  <= 16'd0;
                digit_count <= 2'd0;
                entry_busy  <= 1'b0;
              end
              KC_CLEAR: begin
                // Silent discard.
                state_r     <= ST_IDLE;
                shift_r     <= 8'h00;
                overflow_r  <= 1'b0;
                idle_cnt_r  <= 16'd0;
                digit_count <= 2'd0;
                entry_busy  <= 1'b0;
              end
              default: begin
                // Illegal code discards the entry and is reported.
                entry_error <= 1'b1;
                state_r     <= ST_IDLE;
                shift_r     <= 8'h00;
                overflow_r  <= 1'b0;
                idle_cnt_r  <= 16'd0;
                digit_count <= 2'd0;
                entry_busy  <= 1'b0;
              end
            endcase
          end else if (timeout_hit_s) begin
            // A key on this edge would have taken the branch above, so a
            // key always wins over the timeout.
            entry_timeout <= 1'b1;
            state_r       <= ST_IDLE;
            shift_r       <= 8'h00;
            overflow_r    <= 1'b0;
            idle_cnt_r    <= 16'd0;
            digit_count   <= 2'd0;
            entry_busy    <= 1'b0;
          end else begin
            idle_cnt_r <= idle_next_s;
          end
        end

        default: begin
          // Unreachable encoding: recover to IDLE, password untouched.
          state_r     <= ST_IDLE;
          shift_r     <= 8'h00;
          overflow_r  <= 1'b0;
          idle_cnt_r  <= 16'd0;
          digit_count <= 2'd0;
          entry_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pin_entry_collector.sv
// ---------------------------------------------------------------------------
// tb_pin_entry_collector
//
// Directed bench for pin_entry_collector with TIMEOUT_CYCLES = 8. Each step
// drives one cycle of keypad input, pushes the expected output set into a
// scoreboard queue, and pops/compares it one time unit after the clock edge.
// ---------------------------------------------------------------------------
module tb_pin_entry_collector;

  localparam logic [15:0] TMO = 16'd8;

  logic       clk;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] password;
  logic       password_valid;
  logic       entry_error;
  logic       entry_timeout;
  logic       entry_busy;
  logic [1:0] digit_count;

  typedef struct packed {
    logic [7:0] pw;
    logic       pv;
    logic       er;
    logic       to;
    logic       busy;
    logic [1:0] dc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  pin_entry_collector #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .password      (password),
    .password_valid(password_valid),
    .entry_error   (entry_error),
    .entry_timeout (entry_timeout),
    .entry_busy    (entry_busy),
    .digit_count   (digit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare current DUT outputs with an expected set.
  task automatic compare(input string tag, input exp_t exp);
    exp_t obs;
    obs = '{pw: password, pv: password_valid, er: entry_error,
            to: entry_timeout, busy: entry_busy, dc: digit_count};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed pw=%h valid=%b err=%b tmo=%b busy=%b cnt=%0d expected pw=%h valid=%b err=%b tmo=%b busy=%b cnt=%0d",
             tag, obs.pw, obs.pv, obs.er, obs.to, obs.busy, obs.dc,
             exp.pw, exp.pv, exp.er, exp.to, exp.busy, exp.dc);
    end
  endtask

  // Drive one cycle of input, queue its expected result, then check it.
  task automatic step(input string tag, input logic kv, input logic [3:0] kc,
                      input logic [7:0] pw, input logic pv, input logic er,
                      input logic to, input logic busy, input logic [1:0] dc);
    exp_t e;
    e = '{pw: pw, pv: pv, er: er, to: to, busy: busy, dc: dc};
    @(negedge clk);
    key_valid = kv;
    key_code  = kc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      compare(tag, sb_q.pop_front());
    end
  endtask

  initial begin
    reset     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    #12;
    compare("reset_state", '{pw: 8'h00, pv: 1'b0, er: 1'b0, to: 1'b0, busy: 1'b0, dc: 2'd0});
    @(negedge clk);
    reset = 1'b1;

    // 4, 9, ENTER back to back
    step("a_d4",    1'b1, 4'h4, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    step("a_d9",    1'b1, 4'h9, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    step("a_ent",   1'b1, 4'hB, 8'h49, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    step("a_after", 1'b0, 4'h0, 8'h49, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // single digit then ENTER is rejected
    step("b_d4",    1'b1, 4'h4, 8'h49, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    step("b_ent",   1'b1, 4'hB, 8'h49, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    step("b_after", 1'b0, 4'h0, 8'h49, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // three digits overflow, then a clean 1,2
    step("c_d1",    1'b1, 4'h1, 8'h49, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    step("c_d2",    1'b1, 4'h2, 8'h49, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    step("c_d3",    1'b1, 4'h3, 8'h49, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    step("c_ent",   1'b1, 4'hB, 8'h49, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    step("c_e1",    1'b1, 4'h1, 8'h49, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    step("c_e2",    1'b1, 4'h2, 8'h49, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    step("c_eent",  1'b1, 4'hB, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    step("c_after", 1'b0, 4'h0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // timeout: key at edge K, timeout pulse after edge K+7
    step("d_d4",    1'b1, 4'h4, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    for (int i = 1; i <= 6; i++)
      step("d_wait", 1'b0, 4'h0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    step("d_tmo",   1'b0, 4'h0, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    step("d_tclr",  1'b0, 4'h0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step("d_d9",    1'b1, 4'h9, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    step("d_ent",   1'b1, 4'hB, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

    // CLEAR discards silently, then 0,5 ENTER, then a digit right after ENTER
    step("e_d7",    1'b1, 4'h7, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    step("e_clr",   1'b1, 4'hA, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step("e_d0",    1'b1, 4'h0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    step("e_d5",    1'b1, 4'h5, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    step("e_ent",   1'b1, 4'hB, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    step("e_next",  1'b1, 4'h3, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    step("e_illc",  1'b1, 4'hF, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

    // illegal code and CLEAR in IDLE
    step("f_ille",  1'b1, 4'hE, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    step("f_clr",   1'b1, 4'hA, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step("f_entid", 1'b1, 4'hB, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

    // key on the would-be timeout edge wins and restarts the count
    step("g_d6",    1'b1, 4'h6, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    for (int i = 1; i <= 6; i++)
      step("g_wait", 1'b0, 4'h0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    step("g_race",  1'b1, 4'h7, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    for (int i = 1; i <= 6; i++)
      step("g_wait2", 1'b0, 4'h0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    step("g_tmo",   1'b0, 4'h0, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);

    // asynchronous reset mid-entry
    step("h_d4",    1'b1, 4'h4, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    @(negedge clk);
    key_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    compare("h_async", '{pw: 8'h00, pv: 1'b0, er: 1'b0, to: 1'b0, busy: 1'b0, dc: 2'd0});
    @(negedge clk);
    reset = 1'b1;
    step("h_d4b",   1'b1, 4'h4, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    step("h_d9",    1'b1, 4'h9, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    step("h_ent",   1'b1, 4'hB, 8'h49, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    step("h_after", 1'b0, 4'h0, 8'h49, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
